// File: rtl/code_entry_shreg.sv
// code_entry_shreg
//    Digit-entry shift register for the lock keypad path. New digits enter
//    at the top slot and older digits move toward slot 0. The block supports
//    backspace, cancel, digit counting, full/done/overflow flags and a
//    selectable policy for loads into a full buffer.
//
// Parameters
//    DIGIT_W   : width of one digit slot in bits
//    DEPTH     : number of digit slots (code length), DEPTH >= 2
//    FULL_MODE : 0 = drop new digit when full, 1 = shift anyway (oldest lost)
//
// Ports
//    clk      in   rising-edge clock
//    clr      in   asynchronous active-low reset, clears all state
//    load     in   push data_in as newest digit
//    data_in  in   digit value (no range check)
//    del      in   backspace, remove newest digit
//    cancel   in   synchronous clear of the entry
//    data_o   out  slot k = data_o[k*DIGIT_W +: DIGIT_W], slot DEPTH-1 newest
//    count    out  digits currently held, 0..DEPTH
//    full     out  count == DEPTH
//    done     out  one-cycle pulse when the entry just became full
//    overflow out  one-cycle pulse on a load while full
module code_entry_shreg #(
   parameter int unsigned DIGIT_W   = 4,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned FULL_MODE = 0
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       load,
   input  logic [DIGIT_W-1:0]         data_in,
   input  logic                       del,
   input  logic                       cancel,
   output logic [DIGIT_W*DEPTH-1:0]   data_o,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       done,
   output logic                       overflow
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned BW = DIGIT_W * DEPTH;

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [BW-1:0] data_q, data_d;
   logic [CW-1:0] count_q, count_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;

   logic [BW-1:0] shift_in;
   logic [BW-1:0] shift_out;

   // Load shifts everything one slot toward slot 0 and puts the new digit
   // in the top slot; backspace is the exact inverse with zero fill at slot 0.
   assign shift_in  = {data_in, data_q[BW-1:DIGIT_W]};
   assign shift_out = {data_q[BW-DIGIT_W-1:0], {DIGIT_W{1'b0}}};

   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      if (cancel) begin
         data_d  = '0;
         count_d = '0;
      end else if (load) begin
         if (count_q != CNT_FULL) begin
            data_d  = shift_in;
            count_d = count_q + CNT_ONE;
            done_d  = (count_q == CNT_LAST);
         end else begin
            ovf_d = 1'b1;
            if (FULL_MODE != 0) begin
               data_d = shift_in;
            end
         end
      end else if (del && (count_q != '0)) begin
         data_d  = shift_out;
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         data_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_o   = data_q;
   assign count    = count_q;
   assign full     = (count_q == CNT_FULL);
   assign done     = done_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_code_entry_shreg.sv
module tb_code_entry_shreg;

   localparam int DW = 4;
   localparam int DP = 4;
   localparam int CW = $clog2(DP + 1);

   logic          clk = 1'b0;
   logic          clr = 1'b0;
   logic          load = 1'b0;
   logic          del = 1'b0;
   logic          cancel = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW*DP-1:0] data_o0, data_o1;
   logic [CW-1:0]    count0, count1;
   logic             full0, full1, done0, done1, ovf0, ovf1;

   int tests = 0;
   int fails = 0;

   // reference model: digits held oldest-first, one queue per policy
   int q0[$];
   int q1[$];
   bit exp_done[2];
   bit exp_ovf[2];

   typedef struct {
      bit        c, l, d;
      int        v;
      bit [15:0] d0; int c0; bit dn0, ov0;
      bit [15:0] d1; int c1; bit dn1, ov1;
   } vec_t;
   vec_t vecs[$];

   code_entry_shreg #(.DIGIT_W(DW), .DEPTH(DP), .FULL_MODE(0)) u_drop (
      .clk(clk), .clr(clr), .load(load), .data_in(data_in), .del(del), .cancel(cancel),
      .data_o(data_o0), .count(count0), .full(full0), .done(done0), .overflow(ovf0)
   );

   code_entry_shreg #(.DIGIT_W(DW), .DEPTH(DP), .FULL_MODE(1)) u_shift (
      .clk(clk), .clr(clr), .load(load), .data_in(data_in), .del(del), .cancel(cancel),
      .data_o(data_o1), .count(count1), .full(full1), .done(done1), .overflow(ovf1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int m, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s (mode %0d): got %0h expected %0h at %0t", name, m, act, exp, $time);
      end
   endtask

   task automatic check_dut(input int m, input bit [15:0] ed, input int ec,
                            input bit edn, input bit eov, input string tag);
      if (m == 0) begin
         chk({tag, " data"}, 0, data_o0, ed);
         chk({tag, " count"}, 0, count0, ec);
         chk({tag, " full"}, 0, full0, (ec == DP));
         chk({tag, " done"}, 0, done0, edn);
         chk({tag, " overflow"}, 0, ovf0, eov);
      end else begin
         chk({tag, " data"}, 1, data_o1, ed);
         chk({tag, " count"}, 1, count1, ec);
         chk({tag, " full"}, 1, full1, (ec == DP));
         chk({tag, " done"}, 1, done1, edn);
         chk({tag, " overflow"}, 1, ovf1, eov);
      end
   endtask

   task automatic model_apply(input int m, input bit c, input bit l, input bit d, input int v);
      int q[$];
      if (m == 0) q = q0; else q = q1;
      exp_done[m] = 1'b0;
      exp_ovf[m]  = 1'b0;
      if (c) begin
         q.delete();
      end else if (l) begin
         if (q.size() < DP) begin
            q.push_back(v);
            if (q.size() == DP) exp_done[m] = 1'b1;
         end else begin
            exp_ovf[m] = 1'b1;
            if (m == 1) begin
               void'(q.pop_front());
               q.push_back(v);
            end
         end
      end else if (d && q.size() > 0) begin
         void'(q.pop_back());
      end
      if (m == 0) q0 = q; else q1 = q;
   endtask

   function automatic bit [15:0] model_data(input int m);
      int q[$];
      bit [15:0] r;
      if (m == 0) q = q0; else q = q1;
      r = '0;
      for (int i = 0; i < q.size(); i++)
         r[(DP - q.size() + i) * DW +: DW] = q[i][DW-1:0];
      return r;
   endfunction

   function automatic int model_count(input int m);
      if (m == 0) return q0.size();
      return q1.size();
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input bit c, input bit l, input bit d, input int v,
                      input bit [15:0] d0, input int c0, input bit dn0, input bit ov0,
                      input bit [15:0] d1, input int c1, input bit dn1, input bit ov1);
      vec_t e;
      e.c = c; e.l = l; e.d = d; e.v = v;
      e.d0 = d0; e.c0 = c0; e.dn0 = dn0; e.ov0 = ov0;
      e.d1 = d1; e.c1 = c1; e.dn1 = dn1; e.ov1 = ov1;
      vecs.push_back(e);
   endtask

   initial begin
      // reset state is visible before any clock edge
      #1;
      check_dut(0, 16'h0000, 0, 0, 0, "reset");
      check_dut(1, 16'h0000, 0, 0, 0, "reset");
      @(negedge clk);
      clr = 1'b1;

      //   c  l  d  v   mode0: data   cnt dn ov   mode1: data   cnt dn ov
      add(0, 1, 0, 1,  16'h1000, 1, 0, 0,  16'h1000, 1, 0, 0);
      add(0, 1, 0, 2,  16'h2100, 2, 0, 0,  16'h2100, 2, 0, 0);
      add(0, 1, 0, 3,  16'h3210, 3, 0, 0,  16'h3210, 3, 0, 0);
      add(0, 1, 0, 4,  16'h4321, 4, 1, 0,  16'h4321, 4, 1, 0);
      add(0, 1, 0, 5,  16'h4321, 4, 0, 1,  16'h5432, 4, 0, 1);
      add(0, 0, 1, 0,  16'h3210, 3, 0, 0,  16'h4320, 3, 0, 0);
      add(0, 1, 0, 9,  16'h9321, 4, 1, 0,  16'h9432, 4, 1, 0);
      add(0, 0, 1, 0,  16'h3210, 3, 0, 0,  16'h4320, 3, 0, 0);
      add(0, 0, 1, 0,  16'h2100, 2, 0, 0,  16'h3200, 2, 0, 0);
      add(0, 0, 1, 0,  16'h1000, 1, 0, 0,  16'h2000, 1, 0, 0);
      add(0, 0, 1, 0,  16'h0000, 0, 0, 0,  16'h0000, 0, 0, 0);
      add(0, 0, 1, 0,  16'h0000, 0, 0, 0,  16'h0000, 0, 0, 0);
      add(0, 1, 0, 1,  16'h1000, 1, 0, 0,  16'h1000, 1, 0, 0);
      add(0, 1, 0, 2,  16'h2100, 2, 0, 0,  16'h2100, 2, 0, 0);
      add(0, 1, 1, 7,  16'h7210, 3, 0, 0,  16'h7210, 3, 0, 0);
      add(0, 1, 0, 8,  16'h8721, 4, 1, 0,  16'h8721, 4, 1, 0);
      add(1, 1, 0, 5,  16'h0000, 0, 0, 0,  16'h0000, 0, 0, 0);
      add(0, 1, 0, 1,  16'h1000, 1, 0, 0,  16'h1000, 1, 0, 0);
      add(0, 1, 0, 2,  16'h2100, 2, 0, 0,  16'h2100, 2, 0, 0);
      add(0, 1, 0, 3,  16'h3210, 3, 0, 0,  16'h3210, 3, 0, 0);
      add(0, 1, 0, 4,  16'h4321, 4, 1, 0,  16'h4321, 4, 1, 0);
      add(0, 1, 0, 5,  16'h4321, 4, 0, 1,  16'h5432, 4, 0, 1);
      add(0, 1, 0, 6,  16'h4321, 4, 0, 1,  16'h6543, 4, 0, 1);
      add(0, 0, 0, 0,  16'h4321, 4, 0, 0,  16'h6543, 4, 0, 0);
      add(1, 0, 1, 0,  16'h0000, 0, 0, 0,  16'h0000, 0, 0, 0);

      foreach (vecs[i]) begin
         cancel  = vecs[i].c;
         load    = vecs[i].l;
         del     = vecs[i].d;
         data_in = vecs[i].v[DW-1:0];
         step();
         check_dut(0, vecs[i].d0, vecs[i].c0, vecs[i].dn0, vecs[i].ov0, $sformatf("vec%0d", i));
         check_dut(1, vecs[i].d1, vecs[i].c1, vecs[i].dn1, vecs[i].ov1, $sformatf("vec%0d", i));
      end
      cancel = 0; load = 0; del = 0;

      // asynchronous reset mid-entry, between edges
      load = 1; data_in = 4'd1; step();
      data_in = 4'd2; step();
      load = 0;
      check_dut(0, 16'h2100, 2, 0, 0, "pre-reset");
      #3;
      clr = 1'b0;
      #1;
      check_dut(0, 16'h0000, 0, 0, 0, "async reset");
      check_dut(1, 16'h0000, 0, 0, 0, "async reset");
      @(negedge clk);
      clr = 1'b1;
      step();
      check_dut(0, 16'h0000, 0, 0, 0, "post-reset");
      q0.delete();
      q1.delete();

      // randomized traffic against the queue model
      for (int n = 0; n < 600; n++) begin
         int r;
         r       = $urandom_range(0, 99);
         cancel  = (r < 4);
         load    = ($urandom_range(0, 99) < 55);
         del     = ($urandom_range(0, 99) < 35);
         data_in = DW'($urandom);
         model_apply(0, cancel, load, del, int'(data_in));
         model_apply(1, cancel, load, del, int'(data_in));
         step();
         check_dut(0, model_data(0), model_count(0), exp_done[0], exp_ovf[0], "rand");
         check_dut(1, model_data(1), model_count(1), exp_done[1], exp_ovf[1], "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
